// File: rtl/ram_access_arbiter_if.sv
// Bundle of the CPU, loader and memory-controller signals seen by the RAM arbiter.
// The arbiter uses the slave view; whatever drives the CPU/loader/memory side uses master.
interface ram_access_arbiter_if #(
    parameter int ADDR_W = 27
);
    // CPU side (mapper)
    logic              cpu_ram_cs;
    logic [ADDR_W-1:0] cpu_addr;
    logic              cpu_rnw;
    logic [7:0]        cpu_din;
    logic [7:0]        cpu_dout;
    logic              cpu_wait;
    // Loader side
    logic              ldr_req;
    logic [ADDR_W-1:0] ldr_addr;
    logic [7:0]        ldr_din;
    logic              ldr_ack;
    // Memory controller side
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [7:0]        mem_din;
    logic [7:0]        mem_dout;
    logic              mem_ack;
    // Status
    logic              err;
    logic              err_clr;

    modport slave (
        input  cpu_ram_cs, cpu_addr, cpu_rnw, cpu_din,
        input  ldr_req, ldr_addr, ldr_din,
        input  mem_dout, mem_ack, err_clr,
        output cpu_dout, cpu_wait, ldr_ack,
        output mem_req, mem_addr, mem_we, mem_din, err
    );

    modport master (
        output cpu_ram_cs, cpu_addr, cpu_rnw, cpu_din,
        output ldr_req, ldr_addr, ldr_din,
        output mem_dout, mem_ack, err_clr,
        input  cpu_dout, cpu_wait, ldr_ack,
        input  mem_req, mem_addr, mem_we, mem_din, err
    );
endinterface

// File: rtl/ram_access_arbiter.sv
// Arbitrates a single RAM port between the CPU (mapper) and the ROM loader.
// One memory access per CPU cycle, alternating grant on ties, per-access
// timeout with a sticky error flag.
module ram_access_arbiter #(
    parameter int ADDR_W  = 27,
    parameter int TIMEOUT = 255
) (
    input logic                  clk,
    input logic                  reset_n,
    ram_access_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, CPU_ACC, CPU_HOLD, LDR_ACC} state_t;

    localparam logic        GRANT_CPU = 1'b0;
    localparam logic        GRANT_LDR = 1'b1;
    // Last waiting cycle: if mem_ack is still absent here the counter reaches TIMEOUT.
    localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_we_q, mem_we_d;
    logic [7:0]        mem_din_q, mem_din_d;
    logic [7:0]        cpu_dout_q, cpu_dout_d;
    logic              ldr_ack_q, ldr_ack_d;
    logic              err_q, err_d;
    logic [15:0]       wait_cnt_q, wait_cnt_d;
    logic              last_grant_q, last_grant_d;
    logic              grant_cpu, grant_ldr, timeout;

    // Next-state, grant, completion and timeout decisions.
    always_comb begin
        state_d      = state_q;
        mem_req_d    = mem_req_q;
        mem_addr_d   = mem_addr_q;
        mem_we_d     = mem_we_q;
        mem_din_d    = mem_din_q;
        cpu_dout_d   = cpu_dout_q;
        ldr_ack_d    = 1'b0;
        err_d        = err_q;
        wait_cnt_d   = wait_cnt_q;
        last_grant_d = last_grant_q;
        grant_cpu    = 1'b0;
        grant_ldr    = 1'b0;
        timeout      = 1'b0;

        case (state_q)
            IDLE: begin
                // On a tie the requester that was not served last wins.
                grant_cpu = bus.cpu_ram_cs && (!bus.ldr_req || last_grant_q == GRANT_LDR);
                grant_ldr = bus.ldr_req && !grant_cpu;
                if (grant_cpu) begin
                    mem_addr_d   = bus.cpu_addr;
                    mem_we_d     = !bus.cpu_rnw;
                    mem_din_d    = bus.cpu_din;
                    mem_req_d    = 1'b1;
                    wait_cnt_d   = 16'd0;
                    last_grant_d = GRANT_CPU;
                    state_d      = CPU_ACC;
                end else if (grant_ldr) begin
                    mem_addr_d   = bus.ldr_addr;
                    mem_we_d     = 1'b1;
                    mem_din_d    = bus.ldr_din;
                    mem_req_d    = 1'b1;
                    wait_cnt_d   = 16'd0;
                    last_grant_d = GRANT_LDR;
                    state_d      = LDR_ACC;
                end
            end
            CPU_ACC, LDR_ACC: begin
                // A mem_ack in the last waiting cycle is still a normal completion.
                if (bus.mem_ack || wait_cnt_q == TMO_LAST) begin
                    timeout   = !bus.mem_ack;
                    mem_req_d = 1'b0;
                    if (timeout) begin
                        wait_cnt_d = wait_cnt_q + 16'd1;
                    end
                    if (state_q == CPU_ACC) begin
                        if (!mem_we_q) begin
                            cpu_dout_d = bus.mem_ack ? bus.mem_dout : 8'hFF;
                        end
                        state_d = CPU_HOLD;
                    end else begin
                        ldr_ack_d = 1'b1;
                        state_d   = IDLE;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
            end
            CPU_HOLD: begin
                // Stay here until the CPU ends its cycle so it gets only one access.
                if (!bus.cpu_ram_cs) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A timeout setting err beats a simultaneous clear.
        if (timeout) begin
            err_d = 1'b1;
        end else if (bus.err_clr) begin
            err_d = 1'b0;
        end
    end

    // State and output registers; reset abandons any access in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            mem_we_q     <= 1'b0;
            mem_din_q    <= 8'h00;
            cpu_dout_q   <= 8'hFF;
            ldr_ack_q    <= 1'b0;
            err_q        <= 1'b0;
            wait_cnt_q   <= 16'd0;
            last_grant_q <= GRANT_LDR;
        end else begin
            state_q      <= state_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
            mem_we_q     <= mem_we_d;
            mem_din_q    <= mem_din_d;
            cpu_dout_q   <= cpu_dout_d;
            ldr_ack_q    <= ldr_ack_d;
            err_q        <= err_d;
            wait_cnt_q   <= wait_cnt_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign bus.cpu_wait = bus.cpu_ram_cs && (state_q == IDLE || state_q == CPU_ACC);
    assign bus.cpu_dout = cpu_dout_q;
    assign bus.ldr_ack  = ldr_ack_q;
    assign bus.mem_req  = mem_req_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_we   = mem_we_q;
    assign bus.mem_din  = mem_din_q;
    assign bus.err      = err_q;
endmodule

// File: tb/tb_ram_access_arbiter.sv
// Bench for ram_access_arbiter: directed CPU/loader traffic, a scripted memory
// responder and a transaction-level reference checked every cycle.
module tb_ram_access_arbiter;
    localparam int AW  = 27;
    localparam int TMO = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    ram_access_arbiter_if #(.ADDR_W(AW)) bus ();

    ram_access_arbiter #(.ADDR_W(AW), .TIMEOUT(TMO)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit             cpu;
        logic [AW-1:0]  addr;
        bit             we;
        logic [7:0]     din;
    } acc_t;

    acc_t          expq[$];
    logic [AW:0]   glog[$];
    acc_t          cur;

    // memory responder controls: ack on the ack_at-th request cycle (0 = never)
    int            ack_at  = 1;
    logic [7:0]    rd_data = 8'h00;
    int            resp_cnt = 0;

    // reference state
    bit            prev_req = 1'b0;
    int            len = 0;
    logic [7:0]    exp_dout = 8'hFF;
    bit            exp_err = 1'b0;
    bit            exp_lack = 1'b0;
    bit            done, tmo;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // memory controller model
    initial begin
        bus.mem_ack  = 1'b0;
        bus.mem_dout = 8'h00;
        forever begin
            @(negedge clk);
            if (bus.mem_req === 1'b1) begin
                resp_cnt++;
                bus.mem_ack  = (ack_at != 0 && resp_cnt == ack_at);
                bus.mem_dout = bus.mem_ack ? rd_data : 8'h00;
            end else begin
                resp_cnt     = 0;
                bus.mem_ack  = 1'b0;
                bus.mem_dout = 8'h00;
            end
        end
    end

    // reference: each access in expq must appear on the memory port with its own
    // address/we/data, last at most TMO cycles, and complete with the right side effects
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!reset_n) begin
                expq.delete();
                prev_req = 1'b0;
                len      = 0;
                exp_dout = 8'hFF;
                exp_err  = 1'b0;
                exp_lack = 1'b0;
                chk("rst_mem_req", bus.mem_req, 1'b0);
                chk("rst_cpu_dout", bus.cpu_dout, 8'hFF);
                chk("rst_err", bus.err, 1'b0);
                chk("rst_ldr_ack", bus.ldr_ack, 1'b0);
                continue;
            end
            done = 1'b0;
            tmo  = 1'b0;
            if (prev_req) begin
                len++;
                if (bus.mem_ack) done = 1'b1;
                else if (len == TMO) begin
                    done = 1'b1;
                    tmo  = 1'b1;
                end
            end
            exp_lack = 1'b0;
            if (done) begin
                len = 0;
                if (expq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL completion: no access was expected at %0t", $time);
                end else begin
                    cur = expq.pop_front();
                    if (cur.cpu) begin
                        if (!cur.we) exp_dout = tmo ? 8'hFF : rd_data;
                    end else begin
                        exp_lack = 1'b1;
                    end
                end
                chk("mem_req_drop", bus.mem_req, 1'b0);
            end
            if (tmo) exp_err = 1'b1;
            else if (bus.err_clr) exp_err = 1'b0;
            chk("ldr_ack", bus.ldr_ack, exp_lack);
            chk("cpu_dout", bus.cpu_dout, exp_dout);
            chk("err", bus.err, exp_err);
            if (bus.mem_req) begin
                if (!prev_req) glog.push_back({bus.mem_we, bus.mem_addr});
                if (expq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL access: unexpected mem_req addr %0h at %0t", bus.mem_addr, $time);
                end else begin
                    chk("mem_addr", bus.mem_addr, expq[0].addr);
                    chk("mem_we", bus.mem_we, expq[0].we);
                    if (expq[0].we) chk("mem_din", bus.mem_din, expq[0].din);
                end
            end
            prev_req = bus.mem_req;
        end
    end

    // Start a CPU access on the current negedge and wait until cpu_wait falls.
    task automatic cpu_access(input logic [AW-1:0] a, input bit rnw, input logic [7:0] d,
                              input int ack_n, input logic [7:0] rdv, output int reqs);
        bit ok = 1'b0;
        expq.push_back('{cpu: 1'b1, addr: a, we: !rnw, din: d});
        ack_at = ack_n;
        rd_data = rdv;
        bus.cpu_addr = a;
        bus.cpu_rnw = rnw;
        bus.cpu_din = d;
        bus.cpu_ram_cs = 1'b1;
        reqs = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.mem_req) reqs++;
            if (!bus.cpu_wait) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            total++; bad++;
            $display("FAIL cpu_wait_timeout: cpu_wait still 1 after 40 cycles");
        end
    endtask

    task automatic wait_ldr_ack(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.ldr_ack) begin
                ok = 1'b1;
                break;
            end
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: ldr_ack got 0 expected 1 within 40 cycles", name);
        end
    endtask

    task automatic wait_cpu_free(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!bus.cpu_wait) begin
                ok = 1'b1;
                break;
            end
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: cpu_wait got 1 expected 0 within 40 cycles", name);
        end
    endtask

    int reqs;
    int cnt;
    int base;

    initial begin
        bus.cpu_ram_cs = 1'b0;
        bus.cpu_addr   = '0;
        bus.cpu_rnw    = 1'b1;
        bus.cpu_din    = 8'h00;
        bus.ldr_req    = 1'b0;
        bus.ldr_addr   = '0;
        bus.ldr_din    = 8'h00;
        bus.err_clr    = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_we", bus.mem_we, 1'b0);
        chk("rst_cpu_wait", bus.cpu_wait, 1'b0);

        // tie after reset: CPU, LDR, CPU, LDR
        bus.ldr_req  = 1'b1;
        bus.ldr_addr = 27'h200;
        bus.ldr_din  = 8'h11;
        cpu_access(27'h10, 1'b1, 8'h00, 2, 8'h33, reqs);
        chk("tie_cpu_reqs", reqs, 2);
        chk("tie_cpu_dout", bus.cpu_dout, 8'h33);
        expq.push_back('{cpu: 1'b0, addr: 27'h200, we: 1'b1, din: 8'h11});
        bus.cpu_ram_cs = 1'b0;
        @(negedge clk);
        expq.push_back('{cpu: 1'b1, addr: 27'h20, we: 1'b0, din: 8'h00});
        bus.cpu_addr = 27'h20;
        rd_data = 8'h44;
        bus.cpu_ram_cs = 1'b1;
        wait_ldr_ack("tie_ldr1");
        bus.ldr_addr = 27'h201;
        bus.ldr_din  = 8'h12;
        expq.push_back('{cpu: 1'b0, addr: 27'h201, we: 1'b1, din: 8'h12});
        wait_cpu_free("tie_cpu2");
        chk("tie_cpu2_dout", bus.cpu_dout, 8'h44);
        bus.cpu_ram_cs = 1'b0;
        wait_ldr_ack("tie_ldr2");
        bus.ldr_req = 1'b0;
        chk("tie_grants", glog.size(), 4);
        if (glog.size() == 4) begin
            chk("tie_g0", glog[0], {1'b0, 27'h10});
            chk("tie_g1", glog[1], {1'b1, 27'h200});
            chk("tie_g2", glog[2], {1'b0, 27'h20});
            chk("tie_g3", glog[3], {1'b1, 27'h201});
        end
        repeat (2) @(negedge clk);

        // CPU read, ack on 3rd request cycle
        cpu_access(27'h0004000, 1'b1, 8'h00, 3, 8'h5A, reqs);
        chk("rd_req_cycles", reqs, 3);
        chk("rd_cpu_wait", bus.cpu_wait, 1'b0);
        chk("rd_cpu_dout", bus.cpu_dout, 8'h5A);
        cnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.mem_req) cnt++;
        end
        chk("rd_single_access", cnt, 0);
        bus.cpu_ram_cs = 1'b0;
        repeat (2) @(negedge clk);

        // loader burst with immediate acks
        ack_at = 1;
        base = glog.size();
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            expq.push_back('{cpu: 1'b0, addr: AW'(32'h100 + i), we: 1'b1, din: 8'(8'hA0 + i)});
            bus.ldr_req  = 1'b1;
            bus.ldr_addr = AW'(32'h100 + i);
            bus.ldr_din  = 8'(8'hA0 + i);
            wait_ldr_ack("burst_ack");
            if (bus.ldr_ack) cnt++;
        end
        bus.ldr_req = 1'b0;
        chk("burst_acks", cnt, 4);
        chk("burst_grants", glog.size(), base + 4);
        if (glog.size() == base + 4) begin
            chk("burst_g0", glog[base],   {1'b1, 27'h100});
            chk("burst_g3", glog[base+3], {1'b1, 27'h103});
        end
        repeat (2) @(negedge clk);

        // timeout: no ack ever
        cpu_access(27'h300, 1'b1, 8'h00, 0, 8'h00, reqs);
        chk("tmo_req_cycles", reqs, TMO);
        chk("tmo_cpu_dout", bus.cpu_dout, 8'hFF);
        chk("tmo_err", bus.err, 1'b1);
        bus.cpu_ram_cs = 1'b0;
        @(negedge clk);
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
        chk("errclr_err", bus.err, 1'b0);
        @(negedge clk);

        // ack exactly in the last allowed cycle
        cpu_access(27'h301, 1'b1, 8'h00, TMO, 8'h77, reqs);
        chk("edge_req_cycles", reqs, TMO);
        chk("edge_err", bus.err, 1'b0);
        chk("edge_cpu_dout", bus.cpu_dout, 8'h77);
        bus.cpu_ram_cs = 1'b0;
        repeat (2) @(negedge clk);

        // reset in the middle of a CPU access
        expq.push_back('{cpu: 1'b1, addr: 27'h400, we: 1'b0, din: 8'h00});
        ack_at = 0;
        bus.cpu_addr = 27'h400;
        bus.cpu_rnw = 1'b1;
        bus.cpu_ram_cs = 1'b1;
        repeat (2) @(negedge clk);
        chk("mid_req_before", bus.mem_req, 1'b1);
        reset_n = 1'b0;
        #1;
        chk("async_rst_mem_req", bus.mem_req, 1'b0);
        chk("async_rst_dout", bus.cpu_dout, 8'hFF);
        @(negedge clk);
        reset_n = 1'b1;
        chk("post_rst_wait", bus.cpu_wait, 1'b1);
        bus.cpu_ram_cs = 1'b0;
        cpu_access(27'h400, 1'b1, 8'h00, 2, 8'h42, reqs);
        chk("reserve_reqs", reqs, 2);
        chk("reserve_dout", bus.cpu_dout, 8'h42);
        bus.cpu_ram_cs = 1'b0;
        repeat (3) @(negedge clk);
        chk("leftover_accesses", expq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/ram_access_arbiter.md
RAM_ACCESS_ARBITER -- requirements
Module: ram_access_arbiter

Interface
REQ-001 Parameter ADDR_W, default 27: width of every RAM byte address.
REQ-002 Parameter TIMEOUT, default 255, legal 2..65535: maximum cycles an access waits for mem_ack.
REQ-003 clk  in  1  single system clock; all state changes on the rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 cpu_ram_cs  in  1  mapper RAM chip select; level, held for the whole CPU memory cycle.
REQ-006 cpu_addr  in  ADDR_W  mapper-translated RAM address.
REQ-007 cpu_rnw  in  1  1 = read, 0 = write.
REQ-008 cpu_din  in  8  CPU write data.
REQ-009 cpu_dout  out  8  CPU read data; holds the value of the last completed CPU read.
REQ-010 cpu_wait  out  1  stalls the CPU while its access is outstanding.
REQ-011 ldr_req  in  1  loader write request; level.
REQ-012 ldr_addr  in  ADDR_W  loader write address.
REQ-013 ldr_din  in  8  loader write data.
REQ-014 ldr_ack  out  1  one-cycle pulse when the loader write completes.
REQ-015 mem_req  out  1  request to the memory controller.
REQ-016 mem_addr  out  ADDR_W  registered access address.
REQ-017 mem_we  out  1  1 = write.
REQ-018 mem_din  out  8  registered write data.
REQ-019 mem_dout  in  8  read data; valid in the mem_ack cycle.
REQ-020 mem_ack  in  1  one-cycle completion pulse.
REQ-021 err  out  1  sticky timeout flag.
REQ-022 err_clr  in  1  synchronous clear of err.

Function
REQ-023 The FSM SHALL have exactly four states: IDLE, CPU_ACC, CPU_HOLD and LDR_ACC.
REQ-024 IDLE with exactly one requester pending (cpu_ram_cs or ldr_req) SHALL grant it on that edge: latch the address, data and we into the mem_* registers, set mem_req = 1 from the next cycle, and enter CPU_ACC or LDR_ACC.
REQ-025 With both requesters pending in IDLE, grant SHALL go to the requester not granted last (last_grant register, one bit).
REQ-026 mem_addr, mem_we and mem_din SHALL remain constant while mem_req = 1.
REQ-027 In an ACC state, mem_req SHALL stay 1 until mem_ack is sampled 1, then drop to 0 on that edge.
REQ-028 CPU_ACC + mem_ack: for a read, cpu_dout SHALL be loaded with mem_dout on that edge; the FSM SHALL go to CPU_HOLD.
REQ-029 cpu_wait SHALL be a combinational function: cpu_ram_cs AND (state is IDLE or CPU_ACC).
REQ-030 cpu_wait SHALL therefore deassert the cycle after mem_ack.
REQ-031 CPU_HOLD SHALL stay until cpu_ram_cs = 0, then go to IDLE; each CPU cycle produces exactly one memory access.
REQ-032 LDR_ACC + mem_ack: ldr_ack SHALL pulse 1 for the following cycle and the FSM SHALL go to IDLE.
REQ-033 The loader SHALL deassert ldr_req, or present the next address, in the ldr_ack cycle; ldr_req still high in IDLE is a new request.
REQ-034 A 16-bit wait counter SHALL clear on every grant and increment each ACC-state cycle without mem_ack.
REQ-035 On reaching TIMEOUT without mem_ack, mem_req SHALL drop and err SHALL be set.
REQ-036 On a timeout in CPU_ACC: a read SHALL load cpu_dout = 8'hFF; then go to CPU_HOLD.
REQ-037 On a timeout in LDR_ACC: ldr_ack SHALL pulse; then go to IDLE.
REQ-038 mem_ack in the same cycle the counter reaches TIMEOUT SHALL count as a normal completion, with err unchanged.
REQ-039 err_clr SHALL clear err unless a timeout sets it in the same cycle; set wins.
REQ-040 mem_ack outside an ACC state SHALL be ignored.
REQ-041 cpu_ram_cs dropping during CPU_ACC SHALL NOT abort the access; its completion leads to CPU_HOLD, which exits to IDLE the next cycle.

Reset
REQ-042 reset_n = 0 SHALL immediately force: state IDLE, mem_req 0, mem_we 0, mem_addr 0, mem_din 0, cpu_dout 8'hFF, ldr_ack 0, err 0, counter 0, last_grant = loader (CPU wins the first tie).
REQ-043 Reset during an access SHALL abandon it without waiting for mem_ack; the memory controller is reset by the same signal.

Verification
REQ-044 CPU read: cs = 1, addr 0x0004000, rnw = 1; mem_ack at the 3rd req cycle with mem_dout = 0x5A -> mem_req high exactly 3 cycles, cpu_wait low the next cycle, cpu_dout = 0x5A, and no second mem_req while cs stays high.
REQ-045 Tie: cpu_ram_cs and ldr_req rise together after reset -> CPU is served first, loader next; with both held continuously, grants alternate CPU/LDR/CPU.
REQ-046 Loader burst: 4 writes at 0x100..0x103 with immediate acks -> 4 ldr_ack pulses, mem_we = 1, mem_addr/mem_din matching each write.
REQ-047 Timeout: TIMEOUT = 4, CPU read, mem_ack never arrives -> mem_req drops after 4 cycles, cpu_dout = 0xFF, err = 1; err_clr pulse -> err = 0.
REQ-048 Edge: mem_ack in the exact cycle the counter reaches TIMEOUT -> err stays 0 and data comes from mem_dout.
REQ-049 reset_n pulsed low mid-CPU_ACC -> mem_req 0 without a clock edge; after release the FSM is in IDLE and re-serves the still-asserted cpu_ram_cs.
